tmds_channel_sequencer: RTL and testbench

Per-channel TMDS symbol sequencer wrapping the stage-one transition-minimizing encoder (8-bit in, 9-bit q_m out, combinational, instantiated externally and wired through the st1_* ports).
- Pulls pixel bytes from the data buffer with a valid/ready handshake.
- Performs stage-two DC balancing with a running-disparity counter.
- Emits control tokens during blanking and guard-band tokens at the start of each active period.
- Produces one registered 10-bit symbol per clock toward the serializer.

---
 rtl/tmds_channel_sequencer.sv | 90 +++++++++
 tb/tb_tmds_channel_sequencer.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/tmds_channel_sequencer.sv
// tmds_channel_sequencer: control/guard/data symbol sequencing with stage-two
// DC balancing around an external stage-one encoder.
module tmds_channel_sequencer #(
    parameter int GUARD_LEN = 2
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       de,
    input  logic [1:0] ctrl,
    input  logic       data_valid,
    input  logic [7:0] data_in,
    output logic       data_ready,
    output logic [7:0] st1_in,
    input  logic [8:0] st1_out,
    output logic [9:0] tmds_out,
    output logic       underflow,
    output logic [4:0] disparity
);
    typedef enum logic [1:0] {S_CTRL, S_GUARD, S_DATA} state_t;

    state_t            state, kind_r;
    logic [1:0]        guard_cnt, ctrl_r;
    logic [7:0]        byte_r;
    logic [3:0]        n1;
    logic signed [5:0] diff, disp6, disp_next;
    logic              q8, bal, inv;
    logic [9:0]        ctrl_tok, data_sym;

    assign st1_in     = byte_r;
    assign data_ready = de && (state == S_DATA || (state == S_GUARD && guard_cnt == 2'd0));

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= S_CTRL;
            guard_cnt <= 2'd0;
            kind_r    <= S_CTRL;
            ctrl_r    <= 2'b00;
            byte_r    <= 8'h00;
            underflow <= 1'b0;
        end else begin
            underflow <= 1'b0;
            if (!de) begin
                kind_r <= S_CTRL;
                ctrl_r <= ctrl;
                state  <= S_CTRL;
            end else if (state == S_CTRL) begin
                kind_r    <= S_GUARD;
                guard_cnt <= 2'(GUARD_LEN - 1);
                state     <= S_GUARD;
            end else if (state == S_GUARD && guard_cnt != 2'd0) begin
                kind_r    <= S_GUARD;
                guard_cnt <= guard_cnt - 2'd1;
            end else begin
                // a missing byte is replaced by 0x00 so the symbol stream never stalls
                kind_r    <= S_DATA;
                state     <= S_DATA;
                byte_r    <= data_valid ? data_in : 8'h00;
                underflow <= !data_valid;
            end
        end
    end

    always_comb begin
        n1 = 4'd0;
        for (int i = 0; i < 8; i++) n1 = n1 + {3'd0, st1_out[i]};
        q8        = st1_out[8];
        diff      = $signed({1'b0, n1, 1'b0}) - 6'sd8;
        disp6     = {disparity[4], disparity};
        bal       = disp6 == 6'sd0 || n1 == 4'd4;
        inv       = (disp6 > 6'sd0 && n1 > 4'd4) || (disp6 < 6'sd0 && n1 < 4'd4);
        data_sym  = bal ? {~q8, q8, q8 ? st1_out[7:0] : ~st1_out[7:0]} :
                    inv ? {1'b1, q8, ~st1_out[7:0]} : {1'b0, q8, st1_out[7:0]};
        disp_next = bal ? disp6 + (q8 ? diff : -diff) :
                    inv ? disp6 + (q8 ? 6'sd2 : 6'sd0) - diff :
                          disp6 - (q8 ? 6'sd0 : 6'sd2) + diff;
        ctrl_tok  = ctrl_r == 2'b00 ? 10'b1101010100 :
                    ctrl_r == 2'b01 ? 10'b0010101011 :
                    ctrl_r == 2'b10 ? 10'b0101010100 : 10'b1010101011;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            tmds_out  <= 10'b1101010100;
            disparity <= 5'd0;
        end else begin
            tmds_out  <= kind_r == S_CTRL ? ctrl_tok : kind_r == S_GUARD ? 10'b1011001100 : data_sym;
            disparity <= kind_r == S_DATA ? disp_next[4:0] : 5'd0;
        end
    end
endmodule

// File: tb/tb_tmds_channel_sequencer.sv
// tb_tmds_channel_sequencer: random and directed symbol streams checked against
// a run-length based reference model through a tagged scoreboard.
module tb_tmds_channel_sequencer;
    localparam int GL = 2;

    logic       clk = 1'b0, n_rst = 1'b0, de = 1'b0, data_valid = 1'b0;
    logic [1:0] ctrl = 2'b00;
    logic [7:0] data_in = 8'h00;
    logic       data_ready, underflow;
    logic [7:0] st1_in;
    logic [8:0] st1_out;
    logic [9:0] tmds_out;
    logic [4:0] disparity;

    tmds_channel_sequencer #(.GUARD_LEN(GL)) dut (
        .clk(clk), .n_rst(n_rst), .de(de), .ctrl(ctrl), .data_valid(data_valid),
        .data_in(data_in), .data_ready(data_ready), .st1_in(st1_in), .st1_out(st1_out),
        .tmds_out(tmds_out), .underflow(underflow), .disparity(disparity)
    );

    always #5 clk = ~clk;

    // Stage-one transition-minimizing encoder standing in for the external block
    function automatic logic [8:0] enc(input logic [7:0] d);
        logic [8:0] q;
        int         n;
        logic       xn;
        n    = $countones(d);
        xn   = n > 4 || (n == 4 && !d[0]);
        q[0] = d[0];
        for (int i = 1; i < 8; i++) q[i] = xn ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        q[8] = !xn;
        return q;
    endfunction

    assign st1_out = enc(st1_in);

    function automatic logic [9:0] ctrl_tok(input logic [1:0] c);
        case (c)
            2'b00:   return 10'b1101010100;
            2'b01:   return 10'b0010101011;
            2'b10:   return 10'b0101010100;
            default: return 10'b1010101011;
        endcase
    endfunction

    typedef struct {int tag; logic [9:0] sym; int disp;} sym_t;
    typedef struct {int tag; logic uf;} uf_t;
    sym_t sq[$];
    uf_t  uq[$];
    int   edge_cnt = 0, run = 0, md = 0, n_cmp = 0, n_fail = 0;

    always @(posedge clk) edge_cnt++;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s @edge %0d: got %0d expected %0d", nm, edge_cnt, act, exp);
        end
    endtask

    // Reference: DC balancing from the rule table, tracked as an integer disparity
    task automatic model_data(input logic [8:0] q, output logic [9:0] s);
        int n1, n0;
        n1 = $countones(q[7:0]);
        n0 = 8 - n1;
        if (md == 0 || n1 == n0) begin
            s  = {~q[8], q[8], q[8] ? q[7:0] : ~q[7:0]};
            md = md + (q[8] ? n1 - n0 : n0 - n1);
        end else if ((md > 0 && n1 > n0) || (md < 0 && n0 > n1)) begin
            s  = {1'b1, q[8], ~q[7:0]};
            md = md + 2 * int'(q[8]) + n0 - n1;
        end else begin
            s  = {1'b0, q[8], q[7:0]};
            md = md - 2 * int'(!q[8]) + n1 - n0;
        end
    endtask

    task automatic cycle(input logic d, input logic [1:0] c, input logic v, input logic [7:0] b);
        sym_t       e;
        uf_t        u;
        logic [9:0] s;
        @(negedge clk);
        de = d; ctrl = c; data_valid = v; data_in = b;
        e.tag = edge_cnt + 1;
        u.tag = edge_cnt + 1;
        u.uf  = 1'b0;
        #1 chk("data_ready", int'(data_ready), int'(d && run >= GL));
        if (!d) begin
            run = 0; md = 0; s = ctrl_tok(c);
        end else begin
            run++;
            if (run <= GL) begin
                md = 0; s = 10'b1011001100;
            end else begin
                u.uf = !v;
                model_data(enc(v ? b : 8'h00), s);
            end
        end
        e.sym  = s;
        e.disp = md;
        sq.push_back(e);
        uq.push_back(u);
    endtask

    task automatic do_reset();
        sym_t e;
        @(posedge clk);
        #3 n_rst = 1'b0;
        sq.delete(); uq.delete();
        de = 1'b0; ctrl = 2'b00; data_valid = 1'b0;
        #1;
        chk("rst_tmds", int'(tmds_out), int'(10'b1101010100));
        chk("rst_disparity", int'($signed(disparity)), 0);
        chk("rst_underflow", int'(underflow), 0);
        chk("rst_data_ready", int'(data_ready), 0);
        @(posedge clk);
        #3 n_rst = 1'b1;
        run = 0; md = 0;
        e.tag = edge_cnt; e.sym = 10'b1101010100; e.disp = 0;
        sq.push_back(e);
    endtask

    initial begin : monitor
        sym_t e;
        uf_t  u;
        forever begin
            @(posedge clk);
            #1;
            if (uq.size() > 0 && uq[0].tag == edge_cnt) begin
                u = uq.pop_front();
                chk("underflow", int'(underflow), int'(u.uf));
            end
            if (sq.size() > 0 && sq[0].tag == edge_cnt - 1) begin
                e = sq.pop_front();
                chk("tmds_out", int'(tmds_out), int'(e.sym));
                chk("disparity", int'($signed(disparity)), e.disp);
            end
        end
    end

    initial begin
        do_reset();
        repeat (2) cycle(1'b0, 2'b00, 1'b0, 8'h00);
        repeat (2) cycle(1'b0, 2'b10, 1'b0, 8'h00);
        repeat (GL) cycle(1'b1, 2'b00, 1'b1, 8'h55);
        cycle(1'b1, 2'b00, 1'b1, 8'h00);
        cycle(1'b1, 2'b00, 1'b1, 8'h00);
        cycle(1'b0, 2'b01, 1'b0, 8'h00);
        repeat (GL) cycle(1'b1, 2'b00, 1'b1, 8'h00);
        cycle(1'b1, 2'b00, 1'b1, 8'hFF);
        cycle(1'b1, 2'b00, 1'b0, 8'hA5);
        cycle(1'b1, 2'b00, 1'b1, 8'h3C);
        cycle(1'b0, 2'b11, 1'b0, 8'h00);
        repeat (GL + 4) cycle(1'b1, 2'b00, 1'b1, 8'h81);
        do_reset();
        for (int seg = 0; seg < 60; seg++) begin
            logic [1:0] c;
            c = 2'($urandom_range(0, 3));
            repeat ($urandom_range(1, 5)) cycle(1'b0, c, 1'b0, 8'($urandom));
            repeat ($urandom_range(1, 30))
                cycle(1'b1, 2'b00, 1'($urandom_range(0, 9) != 0), 8'($urandom));
            if (seg == 30) do_reset();
        end
        repeat (3) cycle(1'b0, 2'b00, 1'b0, 8'h00);
        for (int i = 0; i < 10 && sq.size() > 0; i++) @(posedge clk);
        #2;
        if (sq.size() > 0) chk("drain", sq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
